pcs_sync_multi: RTL

//  Parametrised, multi-lane 1000BASE-X PCS receive synchronization block (clause 36 sync FSM).

---
 rtl/pcs_sync_pkg.sv | 25 ++
 rtl/pcs_sync_lane.sv | 135 +++++++++++++
 rtl/pcs_sync_multi.sv | 54 +++++
 3 files changed

// File: rtl/pcs_sync_pkg.sv
// Shared types and code-group constants for the multi-lane 1000BASE-X PCS receive sync block.
// Used by pcs_sync_lane and pcs_sync_multi.
package pcs_sync_pkg;

    typedef enum logic [1:0] {
        LOSS_OF_SYNC  = 2'd0,
        COMMA_DETECT  = 2'd1,
        ACQUIRE_SYNC  = 2'd2,
        SYNC_ACQUIRED = 2'd3
    } sync_state_e;

    // Level index shared by COMMA_DETECT_n, ACQUIRE_SYNC_n and SYNC_ACQUIRED_n.
    localparam int LVL_W = 8;
    typedef logic [LVL_W-1:0] lvl_t;

    localparam logic [6:0] K28_COMMA_P = 7'b0011111;
    localparam logic [6:0] K28_COMMA_N = 7'b1100000;
    localparam logic [9:0] K28_5_N     = 10'b0011111010;
    localparam logic [9:0] K28_5_P     = 10'b1100000101;

    function automatic logic is_comma(input logic [6:0] abcdeif);
        return (abcdeif == K28_COMMA_P) || (abcdeif == K28_COMMA_N);
    endfunction

endpackage

// File: rtl/pcs_sync_lane.sv
// One lane of the PCS receive sync FSM with good_cgs tracking and registered outputs.
// SYNC_STATS_EN adds a 16-bit saturating loss-of-sync counter; otherwise los_cnt is tied to 0.
module pcs_sync_lane
    import pcs_sync_pkg::*;
#(
    parameter int COMMA_CNT    = 3,
    parameter int BAD_LEVELS   = 3,
    parameter int GOOD_CGS_MAX = 4
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        cg_en,
    input  logic [9:0]  rx_code_group,
    input  logic        cg_invalid,
    input  logic        stats_clr,
    output logic [9:0]  rx_code_group_out,
    output logic        sync_status,
    output logic        rx_even,
    output logic        sync_next,
    output logic [15:0] los_cnt
);
    localparam int GW = $clog2(GOOD_CGS_MAX + 1);
    localparam lvl_t           CD_LAST   = lvl_t'(COMMA_CNT);
    localparam lvl_t           SA_LAST   = lvl_t'(1 + BAD_LEVELS);
    localparam logic [GW-1:0]  GOOD_LAST = GW'(GOOD_CGS_MAX - 1);

    sync_state_e   state, state_d;
    lvl_t          lvl, lvl_d;
    logic [GW-1:0] good_cgs, good_d;
    logic          even_d, comma, cgbad, los_event;

    always_ff @(posedge clk) begin
        if (RESET) begin
            state             <= LOSS_OF_SYNC;
            lvl               <= '0;
            good_cgs          <= '0;
            rx_even           <= 1'b0;
            sync_status       <= 1'b0;
            rx_code_group_out <= '0;
        end else if (cg_en) begin
            state             <= state_d;
            lvl               <= lvl_d;
            good_cgs          <= good_d;
            rx_even           <= even_d;
            sync_status       <= (state_d == SYNC_ACQUIRED);
            rx_code_group_out <= rx_code_group;
        end
    end

    always_comb begin
        state_d   = state;
        lvl_d     = lvl;
        good_d    = good_cgs;
        los_event = 1'b0;
        comma     = is_comma(rx_code_group[9:3]);
        cgbad     = cg_invalid | (comma & rx_even);
        case (state)
            LOSS_OF_SYNC: begin
                if (comma && !cg_invalid) begin
                    state_d = COMMA_DETECT;
                    lvl_d   = lvl_t'(1);
                end
            end
            COMMA_DETECT: begin
                if (!comma && !cg_invalid) begin
                    if (lvl == CD_LAST) begin
                        state_d = SYNC_ACQUIRED;
                        lvl_d   = lvl_t'(1);
                        good_d  = '0;
                    end else begin
                        state_d = ACQUIRE_SYNC;
                    end
                end else begin
                    state_d = LOSS_OF_SYNC;
                    lvl_d   = '0;
                end
            end
            ACQUIRE_SYNC: begin
                if (cgbad) begin
                    state_d = LOSS_OF_SYNC;
                    lvl_d   = '0;
                end else if (comma) begin
                    state_d = COMMA_DETECT;
                    lvl_d   = lvl + lvl_t'(1);
                end
            end
            SYNC_ACQUIRED: begin
                if (cgbad) begin
                    good_d = '0;
                    if (lvl == SA_LAST) begin
                        state_d   = LOSS_OF_SYNC;
                        lvl_d     = '0;
                        los_event = 1'b1;
                    end else begin
                        lvl_d = lvl + lvl_t'(1);
                    end
                end else if (lvl != lvl_t'(1)) begin
                    // good_cgs never holds GOOD_CGS_MAX: the step back up clears it instead
                    if (good_cgs == GOOD_LAST) begin
                        lvl_d  = lvl - lvl_t'(1);
                        good_d = '0;
                    end else begin
                        good_d = good_cgs + GW'(1);
                    end
                end
            end
            default: begin
                state_d = LOSS_OF_SYNC;
                lvl_d   = '0;
            end
        endcase
        even_d = (state_d == COMMA_DETECT) ? 1'b1 : ~rx_even;
    end

    assign sync_next = cg_en ? (state_d == SYNC_ACQUIRED) : sync_status;

`ifdef SYNC_STATS_EN
    logic [15:0] los_q;

    always_ff @(posedge clk) begin
        if (RESET || stats_clr) begin
            los_q <= '0;
        end else if (cg_en && los_event && (los_q != 16'hFFFF)) begin
            los_q <= los_q + 16'd1;
        end
    end

    assign los_cnt = los_q;
`else
    logic unused_stats;
    assign unused_stats = stats_clr ^ los_event;
    assign los_cnt      = '0;
`endif

endmodule

// File: rtl/pcs_sync_multi.sv
// N-lane 1000BASE-X PCS receive sync: independent per-lane sync FSMs plus a registered all_sync.
// Build with SYNC_STATS_EN to enable per-lane loss-of-sync counters on los_cnt.
module pcs_sync_multi
    import pcs_sync_pkg::*;
#(
    parameter int NUM_LANES    = 4,
    parameter int COMMA_CNT    = 3,
    parameter int BAD_LEVELS   = 3,
    parameter int GOOD_CGS_MAX = 4
) (
    input  logic                    clk,
    input  logic                    RESET,
    input  logic                    cg_en,
    input  logic [10*NUM_LANES-1:0] rx_code_group,
    input  logic [NUM_LANES-1:0]    cg_invalid,
    output logic [10*NUM_LANES-1:0] rx_code_group_out,
    output logic [NUM_LANES-1:0]    sync_status,
    output logic [NUM_LANES-1:0]    rx_even,
    output logic                    all_sync,
    input  logic                    stats_clr,
    output logic [16*NUM_LANES-1:0] los_cnt
);
    logic [NUM_LANES-1:0] sync_next;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        pcs_sync_lane #(
            .COMMA_CNT    (COMMA_CNT),
            .BAD_LEVELS   (BAD_LEVELS),
            .GOOD_CGS_MAX (GOOD_CGS_MAX)
        ) u_lane (
            .clk               (clk),
            .RESET             (RESET),
            .cg_en             (cg_en),
            .rx_code_group     (rx_code_group[10*i +: 10]),
            .cg_invalid        (cg_invalid[i]),
            .stats_clr         (stats_clr),
            .rx_code_group_out (rx_code_group_out[10*i +: 10]),
            .sync_status       (sync_status[i]),
            .rx_even           (rx_even[i]),
            .sync_next         (sync_next[i]),
            .los_cnt           (los_cnt[16*i +: 16])
        );
    end

    // Fed from each lane's next sync_status so all_sync lands on the same edge
    always_ff @(posedge clk) begin
        if (RESET) begin
            all_sync <= 1'b0;
        end else begin
            all_sync <= &sync_next;
        end
    end

endmodule
